// File: rtl/cube_cursor_ctrl.sv
// LED-cube cursor control: debounced buttons drive a 3-D cursor,
// a colour code and the idle/position/colour mode sequence.
module cube_cursor_ctrl #(
  parameter int SIZE     = 4,
  parameter int DEBOUNCE = 500000,
  parameter int DB_W     = 20
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [3:0] key_n,
  output logic       pos,
  output logic       ccol,
  output logic [2:0] x,
  output logic [2:0] y,
  output logic [2:0] z,
  output logic [2:0] c,
  output logic [1:0] axis,
  output logic       commit
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_POS,
    S_COL
  } state_t;

  localparam logic [DB_W-1:0] DB_MAX =
    DB_W'(DEBOUNCE - 1);
  localparam logic [2:0] C_MAX = 3'(SIZE - 1);

  localparam int B_INC = 0;
  localparam int B_DEC = 1;
  localparam int B_AX  = 2;
  localparam int B_CFM = 3;

  logic [3:0]      s1_q;
  logic [3:0]      s2_q;
  logic [3:0]      db_q;
  logic [3:0]      db_d;
  logic [3:0]      dbr_q;
  logic [3:0]      ev_q;
  logic [3:0]      ev_d;
  logic [DB_W-1:0] cnt_q [4];
  logic [DB_W-1:0] cnt_d [4];

  state_t     state_q;
  state_t     state_d;
  logic [2:0] x_q;
  logic [2:0] x_d;
  logic [2:0] y_q;
  logic [2:0] y_d;
  logic [2:0] z_q;
  logic [2:0] z_d;
  logic [2:0] c_q;
  logic [2:0] c_d;
  logic [1:0] axis_q;
  logic [1:0] axis_d;
  logic       pos_q;
  logic       pos_d;
  logic       ccol_q;
  logic       ccol_d;
  logic       commit_q;
  logic       commit_d;

  logic       do_cfm;
  logic       do_ax;
  logic       do_inc;
  logic       do_dec;
  logic [2:0] sel;
  logic [2:0] sel_nx;

  function automatic logic [2:0] wrap_inc(
    input logic [2:0] v
  );
    return (v == C_MAX) ? 3'd0 : v + 3'd1;
  endfunction

  function automatic logic [2:0] wrap_dec(
    input logic [2:0] v
  );
    return (v == 3'd0) ? C_MAX : v - 3'd1;
  endfunction

  // A level is accepted only after DEBOUNCE consecutive
  // differing samples; any agreeing sample restarts the count.
  always_comb begin
    db_d = db_q;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != db_q[i]) begin
        if (cnt_q[i] == DB_MAX) begin
          db_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
    ev_d = dbr_q & ~db_q;
  end

  // Only the highest-priority event of a cycle is acted on.
  always_comb begin
    do_cfm = ev_q[B_CFM];
    do_ax  = ev_q[B_AX] & ~ev_q[B_CFM];
    do_inc = ev_q[B_INC] & ~ev_q[B_CFM]
           & ~ev_q[B_AX];
    do_dec = ev_q[B_DEC] & ~ev_q[B_CFM]
           & ~ev_q[B_AX] & ~ev_q[B_INC];
  end

  always_comb begin
    unique case (axis_q)
      2'd1:    sel = y_q;
      2'd2:    sel = z_q;
      default: sel = x_q;
    endcase
    sel_nx = do_inc ? wrap_inc(sel)
                    : wrap_dec(sel);
  end

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    z_d      = z_q;
    c_d      = c_q;
    axis_d   = axis_q;
    commit_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (do_cfm) begin
          state_d = S_POS;
          axis_d  = 2'd0;
        end
      end
      S_POS: begin
        unique case (1'b1)
          do_cfm: state_d = S_COL;
          do_ax: begin
            axis_d = (axis_q == 2'd2) ? 2'd0
                                      : axis_q + 2'd1;
          end
          do_inc, do_dec: begin
            unique case (axis_q)
              2'd1:    y_d = sel_nx;
              2'd2:    z_d = sel_nx;
              default: x_d = sel_nx;
            endcase
          end
          default: ;
        endcase
      end
      S_COL: begin
        unique case (1'b1)
          do_cfm: begin
            state_d  = S_IDLE;
            commit_d = 1'b1;
          end
          do_inc:  c_d = c_q + 3'd1;
          do_dec:  c_d = c_q - 3'd1;
          default: ;
        endcase
      end
      default: state_d = S_IDLE;
    endcase
    pos_d  = (state_d == S_POS);
    ccol_d = (state_d == S_COL);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      s1_q     <= 4'hF;
      s2_q     <= 4'hF;
      db_q     <= 4'hF;
      dbr_q    <= 4'hF;
      ev_q     <= 4'h0;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
      end
      state_q  <= S_IDLE;
      x_q      <= 3'd0;
      y_q      <= 3'd0;
      z_q      <= 3'd0;
      c_q      <= 3'd0;
      axis_q   <= 2'd0;
      pos_q    <= 1'b0;
      ccol_q   <= 1'b0;
      commit_q <= 1'b0;
    end else begin
      s1_q     <= key_n;
      s2_q     <= s1_q;
      db_q     <= db_d;
      dbr_q    <= db_q;
      ev_q     <= ev_d;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      z_q      <= z_d;
      c_q      <= c_d;
      axis_q   <= axis_d;
      pos_q    <= pos_d;
      ccol_q   <= ccol_d;
      commit_q <= commit_d;
    end
  end

  assign pos    = pos_q;
  assign ccol   = ccol_q;
  assign x      = x_q;
  assign y      = y_q;
  assign z      = z_q;
  assign c      = c_q;
  assign axis   = axis_q;
  assign commit = commit_q;

endmodule

// File: tb/tb_cube_cursor_ctrl.sv
// Bench for cube_cursor_ctrl: directed vector table, hand-written
// corner sequences and random taps against a tap-level model.
module tb_cube_cursor_ctrl;

  localparam int SIZE = 4;

  logic       clk;
  logic       resetn;
  logic [3:0] key_n;
  logic       pos;
  logic       ccol;
  logic [2:0] x;
  logic [2:0] y;
  logic [2:0] z;
  logic [2:0] c;
  logic [1:0] axis;
  logic       commit;

  int checks;
  int failures;

  // tap-level reference state: 0 idle, 1 position, 2 colour
  int mst;
  int mco [3];
  int mc;
  int max_;
  int mcommit;

  cube_cursor_ctrl #(
    .SIZE(SIZE), .DEBOUNCE(4), .DB_W(3)
  ) dut (
    .clk(clk), .resetn(resetn), .key_n(key_n),
    .pos(pos), .ccol(ccol), .x(x), .y(y), .z(z),
    .c(c), .axis(axis), .commit(commit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] m;
    logic [1:0] kind;
    logic       pos;
    logic       ccol;
    logic [2:0] x;
    logic [2:0] y;
    logic [2:0] z;
    logic [2:0] c;
    logic [1:0] ax;
    logic [1:0] cm;
  } vec_t;

  vec_t tbl [21];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h",
               nm, act, exp);
    end
  endtask

  function automatic logic [15:0] snap();
    return {pos, ccol, x, y, z, c, axis};
  endfunction

  function automatic logic [15:0] mexp();
    return {mst == 1, mst == 2, 3'(mco[0]),
            3'(mco[1]), 3'(mco[2]), 3'(mc), 2'(max_)};
  endfunction

  // One button gesture as the user sees it, at tap granularity.
  task automatic model(input logic [3:0] m);
    mcommit = 0;
    if (m[3]) begin
      if (mst == 0) begin
        mst = 1;
        max_ = 0;
      end else if (mst == 1) begin
        mst = 2;
      end else begin
        mst = 0;
        mcommit = 1;
      end
    end else if (m[2]) begin
      if (mst == 1) max_ = (max_ + 1) % 3;
    end else if (m[0]) begin
      if (mst == 1) mco[max_] = (mco[max_] + 1) % SIZE;
      if (mst == 2) mc = (mc + 1) % 8;
    end else if (m[1]) begin
      if (mst == 1)
        mco[max_] = (mco[max_] + SIZE - 1) % SIZE;
      if (mst == 2) mc = (mc + 7) % 8;
    end
  endtask

  function automatic bit lowat(input int kind, input int i);
    if (kind == 1) return i < 2;
    if (kind == 2) return i == 0 || i == 2 || (i >= 4 && i < 14);
    return i < 10;
  endfunction

  // kind 0 clean press, 1 short glitch, 2 bounce then press
  task automatic tap(input logic [3:0] m, input int kind,
                     output int ncm, output int both);
    ncm = 0;
    both = 0;
    for (int i = 0; i < 30; i++) begin
      key_n = lowat(kind, i) ? ~m : 4'hF;
      @(posedge clk);
      #1;
      if (commit) ncm++;
      if (pos && ccol) both++;
    end
  endtask

  task automatic reset_model();
    mst = 0;
    mco[0] = 0;
    mco[1] = 0;
    mco[2] = 0;
    mc = 0;
    max_ = 0;
  endtask

  initial begin
    int n;
    int ncm;
    int both;
    int r;
    logic [3:0] m;
    int kind;
    checks = 0;
    failures = 0;
    key_n = 4'hF;
    resetn = 1'b0;
    reset_model();

    //        m    kd  p  cc x  y  z  c  ax cm
    tbl[0]  = '{4'h1, 2'd0, 1'b1, 1'b0, 3'd1, 3'd0, 3'd0, 3'd0, 2'd0, 2'd0};
    tbl[1]  = '{4'h1, 2'd0, 1'b1, 1'b0, 3'd2, 3'd0, 3'd0, 3'd0, 2'd0, 2'd0};
    tbl[2]  = '{4'h1, 2'd0, 1'b1, 1'b0, 3'd3, 3'd0, 3'd0, 3'd0, 2'd0, 2'd0};
    tbl[3]  = '{4'h1, 2'd0, 1'b1, 1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 2'd0, 2'd0};
    tbl[4]  = '{4'h1, 2'd0, 1'b1, 1'b0, 3'd1, 3'd0, 3'd0, 3'd0, 2'd0, 2'd0};
    tbl[5]  = '{4'h4, 2'd0, 1'b1, 1'b0, 3'd1, 3'd0, 3'd0, 3'd0, 2'd1, 2'd0};
    tbl[6]  = '{4'h2, 2'd0, 1'b1, 1'b0, 3'd1, 3'd3, 3'd0, 3'd0, 2'd1, 2'd0};
    tbl[7]  = '{4'h1, 2'd1, 1'b1, 1'b0, 3'd1, 3'd3, 3'd0, 3'd0, 2'd1, 2'd0};
    tbl[8]  = '{4'h1, 2'd2, 1'b1, 1'b0, 3'd1, 3'd0, 3'd0, 3'd0, 2'd1, 2'd0};
    tbl[9]  = '{4'h2, 2'd0, 1'b1, 1'b0, 3'd1, 3'd3, 3'd0, 3'd0, 2'd1, 2'd0};
    tbl[10] = '{4'h8, 2'd0, 1'b0, 1'b1, 3'd1, 3'd3, 3'd0, 3'd0, 2'd1, 2'd0};
    tbl[11] = '{4'h2, 2'd0, 1'b0, 1'b1, 3'd1, 3'd3, 3'd0, 3'd7, 2'd1, 2'd0};
    tbl[12] = '{4'h4, 2'd0, 1'b0, 1'b1, 3'd1, 3'd3, 3'd0, 3'd7, 2'd1, 2'd0};
    tbl[13] = '{4'h8, 2'd0, 1'b0, 1'b0, 3'd1, 3'd3, 3'd0, 3'd7, 2'd1, 2'd1};
    tbl[14] = '{4'h1, 2'd0, 1'b0, 1'b0, 3'd1, 3'd3, 3'd0, 3'd7, 2'd1, 2'd0};
    tbl[15] = '{4'h4, 2'd0, 1'b0, 1'b0, 3'd1, 3'd3, 3'd0, 3'd7, 2'd1, 2'd0};
    tbl[16] = '{4'h8, 2'd0, 1'b1, 1'b0, 3'd1, 3'd3, 3'd0, 3'd7, 2'd0, 2'd0};
    tbl[17] = '{4'h9, 2'd0, 1'b0, 1'b1, 3'd1, 3'd3, 3'd0, 3'd7, 2'd0, 2'd0};
    tbl[18] = '{4'h7, 2'd0, 1'b0, 1'b1, 3'd1, 3'd3, 3'd0, 3'd7, 2'd0, 2'd0};
    tbl[19] = '{4'h1, 2'd0, 1'b0, 1'b1, 3'd1, 3'd3, 3'd0, 3'd0, 2'd0, 2'd0};
    tbl[20] = '{4'h2, 2'd0, 1'b0, 1'b1, 3'd1, 3'd3, 3'd0, 3'd7, 2'd0, 2'd0};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {16'h0, snap()}, 32'h0);
    chk("reset_commit", {31'h0, commit}, 32'h0);
    resetn = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // confirm latency: 2 sync + 4 debounce + ev + state
    key_n = 4'b0111;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!pos && n < 30);
    chk("confirm_latency", n, 8);
    for (int i = n; i < 10; i++) begin
      @(posedge clk);
      #1;
    end
    key_n = 4'hF;
    repeat (20) @(posedge clk);
    #1;
    model(4'h8);
    chk("enter_position", {16'h0, snap()},
        {16'h0, 1'b1, 1'b0, 12'h0, 2'd0});

    for (int i = 0; i < 21; i++) begin
      tap(tbl[i].m, int'(tbl[i].kind), ncm, both);
      if (tbl[i].kind != 2'd1) model(tbl[i].m);
      chk($sformatf("vec%0d_out", i), {16'h0, snap()},
          {16'h0, tbl[i].pos, tbl[i].ccol, tbl[i].x,
           tbl[i].y, tbl[i].z, tbl[i].c, tbl[i].ax});
      chk($sformatf("vec%0d_commit", i), ncm,
          int'(tbl[i].cm));
      chk($sformatf("vec%0d_excl", i), both, 0);
    end

    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 15);
      if (r < 10) m = 4'h1 << $urandom_range(0, 3);
      else m = 4'($urandom_range(1, 15));
      r = $urandom_range(0, 7);
      kind = (r == 0) ? 1 : (r == 1) ? 2 : 0;
      tap(m, kind, ncm, both);
      if (kind == 1) mcommit = 0;
      else model(m);
      chk($sformatf("rnd%0d_out m=%0h k=%0d", i, m, kind),
          {16'h0, snap()}, {16'h0, mexp()});
      chk($sformatf("rnd%0d_commit", i), ncm, mcommit);
      chk($sformatf("rnd%0d_excl", i), both, 0);
    end

    // reset in COLOR with an inc press mid-debounce
    for (int i = 0; i < 3 && mst != 2; i++) begin
      tap(4'h8, 0, ncm, both);
      model(4'h8);
    end
    chk("pre_reset_color", {31'h0, ccol}, 32'h1);
    key_n = 4'b1110;
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    reset_model();
    chk("mid_reset_out", {16'h0, snap()}, 32'h0);
    chk("mid_reset_commit", {31'h0, commit}, 32'h0);
    ncm = 0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (commit) ncm++;
      if (snap() != 16'h0) n++;
    end
    key_n = 4'hF;
    repeat (12) @(posedge clk);
    #1;
    chk("held_inc_idle_commit", ncm, 0);
    chk("held_inc_idle_out", n, 0);
    tap(4'h8, 0, ncm, both);
    model(4'h8);
    chk("post_reset_confirm", {16'h0, snap()},
        {16'h0, mexp()});

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
